// File: rtl/jtframe_pocket_cmd.sv
// Host command mailbox for the APF 0xF8 bridge window on Pocket.
// Host writes a command, the core takes it via valid/ready, and the host reads back status and result.
module jtframe_pocket_cmd #(
    parameter logic [31:0] CORE_ID = 32'h4A544652,
    parameter logic [23:0] TIMEOUT = 24'd7_425_000
) (
    input  logic        clk_74a,
    input  logic        reset_n,
    input  logic [31:0] bridge_addr,
    input  logic        bridge_wr,
    input  logic [31:0] bridge_wr_data,
    input  logic        bridge_rd,
    output logic [31:0] cmd_bridge_rd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [15:0] cmd_op,
    output logic [31:0] cmd_param0,
    output logic [31:0] cmd_param1,
    output logic [31:0] cmd_param2,
    input  logic        cmd_done,
    input  logic [15:0] cmd_result,
    output logic        cmd_busy
);

    localparam logic [31:0] ADDR_ID     = 32'hF800_0000;
    localparam logic [31:0] ADDR_CMD    = 32'hF800_1000;
    localparam logic [31:0] ADDR_PARAM0 = 32'hF800_1004;
    localparam logic [31:0] ADDR_PARAM1 = 32'hF800_1008;
    localparam logic [31:0] ADDR_PARAM2 = 32'hF800_100C;
    localparam logic [31:0] ADDR_RESULT = 32'hF800_1010;
    localparam logic [31:0] ADDR_ACK    = 32'hF800_1014;
    localparam logic [15:0] MAGIC       = 16'h434D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] result;
    logic        timeout_flag;
    logic        overrun_flag;
    logic [23:0] counter;
    logic [15:0] status_tag;
    logic [31:0] rd_next;
    logic        wr_cmd_ok;
    logic        param_wr_en;

    // Reads are served regardless of the strobe, which is therefore not needed.
    logic unused_rd;
    assign unused_rd = bridge_rd;

    // Decode helpers for the write side.
    always_comb begin
        wr_cmd_ok   = bridge_wr && (bridge_addr == ADDR_CMD) && (bridge_wr_data[31:16] == MAGIC);
        param_wr_en = bridge_wr && (state != PEND) && (state != WAIT);
    end

    // Status word tag and read-data multiplexer, using pre-write register values.
    always_comb begin
        status_tag = 16'h4944;
        case (state)
            IDLE:       status_tag = 16'h4944;
            PEND, WAIT: status_tag = 16'h4255;
            DONE:       status_tag = 16'h4F4B;
            default:    status_tag = 16'h4944;
        endcase
        rd_next = 32'h0;
        case (bridge_addr)
            ADDR_ID:     rd_next = CORE_ID;
            ADDR_CMD:    rd_next = {status_tag, cmd_op};
            ADDR_PARAM0: rd_next = cmd_param0;
            ADDR_PARAM1: rd_next = cmd_param1;
            ADDR_PARAM2: rd_next = cmd_param2;
            ADDR_RESULT: rd_next = {overrun_flag, timeout_flag, 14'd0, result};
            default:     rd_next = 32'h0;
        endcase
    end

    // Command state machine, parameter registers and registered read port.
    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            state              <= IDLE;
            cmd_valid          <= 1'b0;
            cmd_busy           <= 1'b0;
            cmd_op             <= 16'd0;
            cmd_param0         <= 32'd0;
            cmd_param1         <= 32'd0;
            cmd_param2         <= 32'd0;
            result             <= 16'd0;
            timeout_flag       <= 1'b0;
            overrun_flag       <= 1'b0;
            counter            <= 24'd0;
            cmd_bridge_rd_data <= 32'd0;
        end else begin
            cmd_bridge_rd_data <= rd_next;

            if (param_wr_en) begin
                case (bridge_addr)
                    ADDR_PARAM0: cmd_param0 <= bridge_wr_data;
                    ADDR_PARAM1: cmd_param1 <= bridge_wr_data;
                    ADDR_PARAM2: cmd_param2 <= bridge_wr_data;
                    default:     ;
                endcase
            end

            case (state)
                IDLE, DONE: begin
                    if (wr_cmd_ok) begin
                        cmd_op       <= bridge_wr_data[15:0];
                        timeout_flag <= 1'b0;
                        overrun_flag <= 1'b0;
                        cmd_valid    <= 1'b1;
                        cmd_busy     <= 1'b1;
                        state        <= PEND;
                    end else if (state == DONE && bridge_wr && bridge_addr == ADDR_ACK) begin
                        state <= IDLE;
                    end
                end
                PEND: begin
                    if (wr_cmd_ok) begin
                        overrun_flag <= 1'b1;
                    end
                    // A done pulse here belongs to no command and is dropped.
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        counter   <= 24'd0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (wr_cmd_ok) begin
                        overrun_flag <= 1'b1;
                    end
                    if (counter != 24'hFF_FFFF) begin
                        counter <= counter + 24'd1;
                    end
                    // Completion from the core takes priority over an expiring timer.
                    if (cmd_done) begin
                        result   <= cmd_result;
                        cmd_busy <= 1'b0;
                        state    <= DONE;
                    end else if (counter == TIMEOUT - 24'd1) begin
                        result       <= 16'hFFFF;
                        timeout_flag <= 1'b1;
                        cmd_busy     <= 1'b0;
                        state        <= DONE;
                    end
                end
                default: begin
                    cmd_valid <= 1'b0;
                    cmd_busy  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_pocket_cmd.sv
// Directed bench for jtframe_pocket_cmd: a vector table for the register map plus
// hand-written sequences for handshake, completion, timeout, overrun and reset.
module tb_jtframe_pocket_cmd;

    logic        clk_74a = 1'b0;
    logic        reset_n;
    logic [31:0] bridge_addr;
    logic        bridge_wr;
    logic [31:0] bridge_wr_data;
    logic        bridge_rd;
    logic [31:0] cmd_bridge_rd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_op;
    logic [31:0] cmd_param0, cmd_param1, cmd_param2;
    logic        cmd_done;
    logic [15:0] cmd_result;
    logic        cmd_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk_74a = ~clk_74a;

    jtframe_pocket_cmd #(.CORE_ID(32'h4A544652), .TIMEOUT(24'd16)) dut (
        .clk_74a(clk_74a),
        .reset_n(reset_n),
        .bridge_addr(bridge_addr),
        .bridge_wr(bridge_wr),
        .bridge_wr_data(bridge_wr_data),
        .bridge_rd(bridge_rd),
        .cmd_bridge_rd_data(cmd_bridge_rd_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_param0(cmd_param0),
        .cmd_param1(cmd_param1),
        .cmd_param2(cmd_param2),
        .cmd_done(cmd_done),
        .cmd_result(cmd_result),
        .cmd_busy(cmd_busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bridge cycle: present address/write, let the edge pass, sample 1 ns later.
    task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d);
        bridge_addr    = a;
        bridge_wr      = w;
        bridge_wr_data = d;
        @(posedge clk_74a);
        #1;
        bridge_wr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        bridge_addr = 32'h0; bridge_wr = 1'b0; bridge_wr_data = 32'h0; bridge_rd = 1'b1;
        cmd_ready = 1'b0; cmd_done = 1'b0; cmd_result = 16'h0;

        vecs[0]  = '{32'hF8000000, 1'b0, 32'h0,        32'h4A544652, 1'b0};
        vecs[1]  = '{32'hF8001000, 1'b0, 32'h0,        32'h49440000, 1'b0};
        vecs[2]  = '{32'hF8001004, 1'b1, 32'h11,       32'h00000000, 1'b0};
        vecs[3]  = '{32'hF8001008, 1'b1, 32'h22,       32'h00000000, 1'b0};
        vecs[4]  = '{32'hF800100C, 1'b1, 32'h33,       32'h00000000, 1'b0};
        vecs[5]  = '{32'hF8001004, 1'b0, 32'h0,        32'h00000011, 1'b0};
        vecs[6]  = '{32'hF8001008, 1'b0, 32'h0,        32'h00000022, 1'b0};
        vecs[7]  = '{32'hF800100C, 1'b0, 32'h0,        32'h00000033, 1'b0};
        vecs[8]  = '{32'hF8001000, 1'b1, 32'h12340001, 32'h49440000, 1'b0};
        vecs[9]  = '{32'hF8001000, 1'b0, 32'h0,        32'h49440000, 1'b0};
        vecs[10] = '{32'hF8001010, 1'b0, 32'h0,        32'h00000000, 1'b0};
        vecs[11] = '{32'hF8001000, 1'b1, 32'h434D0005, 32'h49440000, 1'b1};
        vecs[12] = '{32'hF8001000, 1'b0, 32'h0,        32'h42550005, 1'b1};
        vecs[13] = '{32'hF8001004, 1'b0, 32'h0,        32'h00000011, 1'b1};
        vecs[14] = '{32'hF8001004, 1'b1, 32'h99,       32'h00000011, 1'b1};
        vecs[15] = '{32'hF8001004, 1'b0, 32'h0,        32'h00000011, 1'b1};
        vecs[16] = '{32'hF8002000, 1'b0, 32'h0,        32'h00000000, 1'b1};

        // Reset state
        step(32'hF8000000, 1'b0, 32'h0);
        step(32'hF8000000, 1'b0, 32'h0);
        chk("rst_rd", cmd_bridge_rd_data, 32'h0);
        chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_busy", {31'd0, cmd_busy}, 32'd0);
        chk("rst_op", {16'd0, cmd_op}, 32'd0);
        reset_n = 1'b1;

        // Register map table
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].addr, vecs[i].wr, vecs[i].data);
            chk($sformatf("vec%0d_rd", i), cmd_bridge_rd_data, vecs[i].exp_rd);
            chk($sformatf("vec%0d_valid", i), {31'd0, cmd_valid}, {31'd0, vecs[i].exp_valid});
        end

        // Command held while the core is not ready
        for (int i = 0; i < 10; i++) begin
            step(32'hF8001000, 1'b0, 32'h0);
            chk($sformatf("pend%0d_status", i), cmd_bridge_rd_data, 32'h42550005);
            chk($sformatf("pend%0d_valid", i), {31'd0, cmd_valid}, 32'd1);
        end
        chk("pend_op", {16'd0, cmd_op}, 32'h5);
        chk("pend_p0", cmd_param0, 32'h11);
        chk("pend_p1", cmd_param1, 32'h22);
        chk("pend_p2", cmd_param2, 32'h33);

        // Handshake, with a done on the same cycle that must be ignored
        cmd_ready = 1'b1; cmd_done = 1'b1; cmd_result = 16'h1234;
        step(32'hF8001000, 1'b0, 32'h0);
        cmd_ready = 1'b0; cmd_done = 1'b0;
        chk("hs_valid", {31'd0, cmd_valid}, 32'd0);
        chk("hs_busy", {31'd0, cmd_busy}, 32'd1);
        for (int i = 0; i < 4; i++) step(32'hF8001000, 1'b0, 32'h0);
        chk("wait_status", cmd_bridge_rd_data, 32'h42550005);
        cmd_done = 1'b1; cmd_result = 16'h00A5;
        step(32'hF8001000, 1'b0, 32'h0);
        cmd_done = 1'b0;
        chk("done_busy", {31'd0, cmd_busy}, 32'd0);
        step(32'hF8001000, 1'b0, 32'h0);
        chk("done_status", cmd_bridge_rd_data, 32'h4F4B0005);
        step(32'hF8001010, 1'b0, 32'h0);
        chk("done_result", cmd_bridge_rd_data, 32'h000000A5);
        step(32'hF8001014, 1'b1, 32'h0);
        step(32'hF8001000, 1'b0, 32'h0);
        chk("ack_status", cmd_bridge_rd_data, 32'h49440005);

        // Timeout: DONE exactly 16 cycles after the handshake
        step(32'hF8001000, 1'b1, 32'h434D0007);
        cmd_ready = 1'b1;
        step(32'hF8001000, 1'b0, 32'h0);
        cmd_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step(32'hF8001000, 1'b0, 32'h0);
            chk($sformatf("to_busy%0d", i), {31'd0, cmd_busy}, (i < 16) ? 32'd1 : 32'd0);
        end
        step(32'hF8001010, 1'b0, 32'h0);
        chk("to_result", cmd_bridge_rd_data, 32'h4000FFFF);
        step(32'hF8001000, 1'b0, 32'h0);
        chk("to_status", cmd_bridge_rd_data, 32'h4F4B0007);

        // Overrun while waiting, then done coinciding with the timeout
        step(32'hF8001000, 1'b1, 32'h434D0005);
        cmd_ready = 1'b1;
        step(32'hF8001000, 1'b0, 32'h0);
        cmd_ready = 1'b0;
        step(32'hF8001000, 1'b1, 32'h434D0009);
        step(32'hF8001004, 1'b1, 32'h99);
        step(32'hF8001000, 1'b0, 32'h0);
        chk("ovr_status", cmd_bridge_rd_data, 32'h42550005);
        step(32'hF8001004, 1'b0, 32'h0);
        chk("ovr_p0", cmd_bridge_rd_data, 32'h11);
        step(32'hF8001010, 1'b0, 32'h0);
        chk("ovr_flags", cmd_bridge_rd_data, 32'h8000FFFF);
        for (int i = 0; i < 10; i++) step(32'hF8001000, 1'b0, 32'h0);
        chk("coinc_busy_before", {31'd0, cmd_busy}, 32'd1);
        cmd_done = 1'b1; cmd_result = 16'h0042;
        step(32'hF8001000, 1'b0, 32'h0);
        cmd_done = 1'b0;
        chk("coinc_busy_after", {31'd0, cmd_busy}, 32'd0);
        step(32'hF8001010, 1'b0, 32'h0);
        chk("coinc_result", cmd_bridge_rd_data, 32'h80000042);

        // Reset during PEND drops the command
        step(32'hF8001014, 1'b1, 32'h0);
        step(32'hF8001000, 1'b1, 32'h434D0003);
        chk("rp_valid_before", {31'd0, cmd_valid}, 32'd1);
        reset_n = 1'b0;
        step(32'hF8001000, 1'b0, 32'h0);
        chk("rp_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rp_busy", {31'd0, cmd_busy}, 32'd0);
        chk("rp_rd", cmd_bridge_rd_data, 32'h0);
        reset_n = 1'b1;
        step(32'hF8001000, 1'b0, 32'h0);
        chk("rp_status", cmd_bridge_rd_data, 32'h49440000);
        step(32'hF8001004, 1'b0, 32'h0);
        chk("rp_p0", cmd_bridge_rd_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
